// File: rtl/ir_fetch_sequencer.sv
// Instruction fetch sequencer: reads 4-byte bundles from the instruction cache and hands them to decode.
// Optional IR_ILLEGAL_OP_CHECK_EN: halts with illegal_op instead of issuing opcodes outside the ISA.
module ir_fetch_sequencer #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cache_init_load_finished,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [DATA_WIDTH-1:0] ir_op,
  output logic [DATA_WIDTH-1:0] ir_p0,
  output logic [DATA_WIDTH-1:0] ir_p1,
  output logic [DATA_WIDTH-1:0] ir_p2,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
`ifdef IR_ILLEGAL_OP_CHECK_EN
  ,
  output logic                  illegal_op
`endif
);

  localparam logic [DATA_WIDTH-1:0] OP_JUMP = DATA_WIDTH'(8'h02);
  localparam logic [DATA_WIDTH-1:0] OP_STOP = DATA_WIDTH'(8'h0E);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_FETCH_OP,
    S_FETCH_P0,
    S_FETCH_P1,
    S_FETCH_P2,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fptr_q, fptr_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] op_q, op_d, p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  mem_req_q, ir_valid_q, halted_q;
  logic                  accept_redir, redir_live, fetching;
  logic [ADDR_WIDTH-1:0] redir_tgt, next_pc;

`ifdef IR_ILLEGAL_OP_CHECK_EN
  logic illegal_q, illegal_d;

  function automatic logic op_is_legal(input logic [DATA_WIDTH-1:0] op);
    return op inside {DATA_WIDTH'(8'h00), DATA_WIDTH'(8'h02), DATA_WIDTH'(8'h0E), DATA_WIDTH'(8'h0F),
                      DATA_WIDTH'(8'h10), DATA_WIDTH'(8'h11), DATA_WIDTH'(8'h12), DATA_WIDTH'(8'h20),
                      DATA_WIDTH'(8'h21), DATA_WIDTH'(8'h22), DATA_WIDTH'(8'h23), DATA_WIDTH'(8'h28),
                      DATA_WIDTH'(8'h29), DATA_WIDTH'(8'h2A), DATA_WIDTH'(8'h80), DATA_WIDTH'(8'h81)};
  endfunction
`endif

  // Next-state, fetch pointer, byte capture and redirect bookkeeping
  always_comb begin
    state_d     = state_q;
    fptr_d      = fptr_q;
    pc_d        = pc_q;
    op_d        = op_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    next_pc     = fptr_q;
`ifdef IR_ILLEGAL_OP_CHECK_EN
    illegal_d   = illegal_q;
`endif

    accept_redir = (state_q != S_WAIT_INIT) && (state_q != S_HALT) && redirect;
    redir_live   = pend_q || accept_redir;
    redir_tgt    = redirect ? redirect_addr : pend_addr_q;
    fetching     = state_q inside {S_FETCH_OP, S_FETCH_P0, S_FETCH_P1, S_FETCH_P2};

    if (accept_redir) begin
      pend_d      = 1'b1;
      pend_addr_d = redirect_addr;
    end

    case (state_q)
      S_WAIT_INIT: if (cache_init_load_finished) state_d = S_FETCH_OP;
      S_FETCH_OP:  if (mem_ack) begin op_d = mem_rdata; state_d = S_FETCH_P0; end
      S_FETCH_P0:  if (mem_ack) begin p0_d = mem_rdata; state_d = S_FETCH_P1; end
      S_FETCH_P1:  if (mem_ack) begin p1_d = mem_rdata; state_d = S_FETCH_P2; end
      S_FETCH_P2: begin
        if (mem_ack) begin
          p2_d    = mem_rdata;
          state_d = S_ISSUE;
`ifdef IR_ILLEGAL_OP_CHECK_EN
          if (!redir_live && !op_is_legal(op_q)) begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
            pend_d    = 1'b0;
          end
`endif
        end
      end
      S_ISSUE: begin
        if (ir_ready) begin
          pend_d = 1'b0;
          if (op_q == OP_STOP) begin
            state_d = S_HALT;
          end else begin
            if (redir_live)           next_pc = redir_tgt;
            else if (op_q == OP_JUMP) next_pc = ADDR_WIDTH'(p0_q);
            else                      next_pc = fptr_q;
            state_d = S_FETCH_OP;
            pc_d    = next_pc;
            fptr_d  = next_pc;
          end
        end else if (redir_live) begin
          state_d = S_FETCH_OP;
          pc_d    = redir_tgt;
          fptr_d  = redir_tgt;
          pend_d  = 1'b0;
        end
      end
      S_HALT: begin
        if (restart) begin
          state_d = S_FETCH_OP;
          pc_d    = RESET_PC;
          fptr_d  = RESET_PC;
          pend_d  = 1'b0;
`ifdef IR_ILLEGAL_OP_CHECK_EN
          illegal_d = 1'b0;
`endif
        end
      end
      default: state_d = S_WAIT_INIT;
    endcase

    // A completed byte request either advances the bundle or, when squashed, restarts at the target
    if (fetching && mem_ack) begin
      fptr_d = fptr_q + ADDR_WIDTH'(1);
      if (redir_live) begin
        state_d = S_FETCH_OP;
        pc_d    = redir_tgt;
        fptr_d  = redir_tgt;
        pend_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_WAIT_INIT;
      fptr_q      <= RESET_PC;
      pc_q        <= RESET_PC;
      op_q        <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      mem_req_q   <= 1'b0;
      ir_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
`ifdef IR_ILLEGAL_OP_CHECK_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fptr_q      <= fptr_d;
      pc_q        <= pc_d;
      op_q        <= op_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      mem_req_q   <= state_d inside {S_FETCH_OP, S_FETCH_P0, S_FETCH_P1, S_FETCH_P2};
      ir_valid_q  <= (state_d == S_ISSUE);
      halted_q    <= (state_d == S_HALT);
`ifdef IR_ILLEGAL_OP_CHECK_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = fptr_q;
  assign ir_valid = ir_valid_q;
  assign ir_op    = op_q;
  assign ir_p0    = p0_q;
  assign ir_p1    = p1_q;
  assign ir_p2    = p2_q;
  assign pc       = pc_q;
  assign halted   = halted_q;
`ifdef IR_ILLEGAL_OP_CHECK_EN
  assign illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Scoreboard bench for ir_fetch_sequencer: an ISA-level program walker predicts fetch addresses and issued bundles.
module tb_ir_fetch_sequencer;

  localparam logic [7:0] RST_PC = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n, init, mem_req, mem_ack, ir_valid, ir_ready, redirect, restart, halted;
  logic [7:0] mem_addr, mem_rdata, ir_op, ir_p0, ir_p1, ir_p2, redirect_addr, pc;
`ifdef IR_ILLEGAL_OP_CHECK_EN
  logic       illegal_op;
`endif

  always #5 clk = ~clk;

  ir_fetch_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .cache_init_load_finished(init),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_op(ir_op), .ir_p0(ir_p0), .ir_p1(ir_p1), .ir_p2(ir_p2),
    .redirect(redirect), .redirect_addr(redirect_addr), .restart(restart),
    .pc(pc), .halted(halted)
`ifdef IR_ILLEGAL_OP_CHECK_EN
    , .illegal_op(illegal_op)
`endif
  );

  typedef struct packed {
    logic [7:0] pc, op, p0, p1, p2;
  } bundle_t;

  typedef enum int {M_FETCH, M_ISSUE, M_HALT} mode_t;

  logic [7:0] mem [256];
  bundle_t    exp_q [$];
  bundle_t    e;
  int         tests = 0, fails = 0, pushed = 0, popped = 0;

  // Architectural model state
  mode_t      mode;
  logic [7:0] mpc, tgt;
  int         k, plan, stall_left, halt_cnt, bundle_no;
  bit         fired, rnd;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t bundle_at(input logic [7:0] a);
    bundle_t b;
    b.pc = a;
    b.op = mem[a];
    b.p0 = mem[8'(a + 8'd1)];
    b.p1 = mem[8'(a + 8'd2)];
    b.p2 = mem[8'(a + 8'd3)];
    return b;
  endfunction

  // plan: -1 none, 0..3 redirect while waiting for byte k, 4 redirect in ISSUE before handshake, 5 with handshake
  task automatic plan_bundle();
    k = 0; fired = 1'b0;
    if (!rnd) begin
      plan       = (bundle_no == 6) ? 2 : -1;
      tgt        = 8'h80;
      stall_left = (bundle_no == 1) ? 5 : 0;
    end else begin
      plan       = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : -1;
      tgt        = 8'($urandom);
      stall_left = $urandom_range(0, 3);
    end
    bundle_no++;
  endtask

  // Monitor: every handshake pops the oldest predicted bundle
  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 40'(exp_q.size()), 40'(1));
      end else begin
        bundle_t x;
        x = exp_q.pop_front();
        popped++;
        check("issued_bundle", {8'h00, ir_op, ir_p0, ir_p1, ir_p2}, {8'h00, x.op, x.p0, x.p1, x.p2});
        check("issued_pc", 40'(pc), 40'(x.pc));
      end
    end
  end

  task automatic step();
    bit ack;
    redirect = 1'b0; restart = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
    case (mode)
      M_FETCH: begin
        check("fetch_req", 40'(mem_req), 40'(1'b1));
        if (plan == k && !fired) begin
          redirect = 1'b1; redirect_addr = tgt; fired = 1'b1;
        end else if (rnd && fired && $urandom_range(0, 2) == 0) begin
          tgt = 8'($urandom); redirect = 1'b1; redirect_addr = tgt;
        end
        if (rnd && $urandom_range(0, 19) == 0) restart = 1'b1;
        ack = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (ack) begin
          mem_ack   = 1'b1;
          check("fetch_addr", 40'(mem_addr), 40'(8'(mpc + 8'(k))));
          mem_rdata = mem[8'(mpc + 8'(k))];
          k++;
          if (fired) begin
            mpc = tgt;
            plan_bundle();
          end else if (k == 4) begin
            mode = M_ISSUE;
          end
        end
      end
      M_ISSUE: begin
        e = bundle_at(mpc);
        check("issue_flags", 40'({ir_valid, mem_req, halted}), 40'(3'b100));
        check("issue_hold", {8'h00, ir_op, ir_p0, ir_p1, ir_p2}, {8'h00, e.op, e.p0, e.p1, e.p2});
        check("issue_pc", 40'(pc), 40'(mpc));
        if (stall_left > 0) begin
          stall_left--;
        end else if (plan == 4 && !fired) begin
          redirect = 1'b1; redirect_addr = tgt;
          mpc = tgt; mode = M_FETCH; plan_bundle();
        end else if (!rnd || $urandom_range(0, 2) != 0) begin
          ir_ready = 1'b1;
          exp_q.push_back(e);
          pushed++;
          if (plan == 5) begin redirect = 1'b1; redirect_addr = tgt; end
          if (e.op == 8'h0E) begin
            mode = M_HALT;
            halt_cnt = rnd ? int'($urandom_range(1, 4)) : 3;
          end else begin
            mpc  = (plan == 5) ? tgt : ((e.op == 8'h02) ? e.p0 : 8'(mpc + 8'd4));
            mode = M_FETCH;
            plan_bundle();
          end
        end
      end
      default: begin
        check("halt_flags", 40'({halted, mem_req, ir_valid}), 40'(3'b100));
        if ($urandom_range(0, 1) == 0) begin redirect = 1'b1; redirect_addr = 8'($urandom); end
        if (halt_cnt == 0) begin
          if (!rnd && bundle_no >= 8) begin
            rnd = 1'b1;
            for (int i = 0; i < 256; i++) begin
              int r;
              r = $urandom_range(0, 15);
              mem[i] = (r == 0) ? 8'h0E : ((r < 3) ? 8'h02 : 8'($urandom));
            end
          end
          restart = 1'b1; mpc = RST_PC; mode = M_FETCH; plan_bundle();
        end else begin
          halt_cnt--;
        end
      end
    endcase
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h20; mem[8'h01] = 8'h01; mem[8'h02] = 8'h02; mem[8'h03] = 8'h03;
    mem[8'h04] = 8'h21; mem[8'h05] = 8'h04; mem[8'h06] = 8'h05; mem[8'h07] = 8'h06;
    mem[8'h08] = 8'h02; mem[8'h09] = 8'h40; mem[8'h0A] = 8'h00; mem[8'h0B] = 8'h00;
    mem[8'h40] = 8'h02; mem[8'h41] = 8'hFE; mem[8'h42] = 8'h00; mem[8'h43] = 8'h00;
    mem[8'hFE] = 8'h02; mem[8'hFF] = 8'h60;
    mem[8'h60] = 8'h0E; mem[8'h61] = 8'h00; mem[8'h62] = 8'h00; mem[8'h63] = 8'h00;
    mem[8'h80] = 8'h0E; mem[8'h81] = 8'h11; mem[8'h82] = 8'h22; mem[8'h83] = 8'h33;

    rst_n = 1'b0; init = 1'b0; mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
    redirect = 1'b0; redirect_addr = '0; restart = 1'b0;
    rnd = 1'b0; bundle_no = 0; halt_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 40'({mem_req, ir_valid, halted}), 40'(3'b000));
    check("reset_regs", {mem_addr, pc, ir_op, ir_p0, ir_p1}, {RST_PC, RST_PC, 24'h0});
    check("reset_p2", 40'(ir_p2), 40'(0));
    rst_n = 1'b1;

    // Cache still loading: redirect/restart must be ignored
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("wait_init", {7'h0, mem_req, ir_valid, halted, 6'h0, pc, mem_addr, 8'h0},
            {10'h0, 6'h0, RST_PC, RST_PC, 8'h0});
      redirect = (c % 3 == 1); redirect_addr = 8'hC4; restart = (c == 5);
    end
    @(posedge clk); #1;
    redirect = 1'b0; restart = 1'b0; init = 1'b1;
    mpc = RST_PC; mode = M_FETCH; plan_bundle();

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (c == 150) init = 1'b0;
      step();
    end

    // Reset in the middle of a fetch abandons the request
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      step();
      if (mode == M_FETCH && k > 0) break;
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; ir_ready = 1'b0; redirect = 1'b0; restart = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_flags", 40'({mem_req, ir_valid, halted}), 40'(3'b000));
    check("midreset_regs", {mem_addr, pc, ir_op, ir_p0, ir_p1}, {RST_PC, RST_PC, 24'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("sb_drained", 40'(exp_q.size()), 40'(0));
    check("sb_count", 40'(popped), 40'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ir_fetch_sequencer.md
Name: ir_fetch_sequencer

Overview:
- Sequences instruction fetch for the black_bean core.
- Waits for the instruction cache initial load, then walks a program counter (PC) over the instruction cache.
- Per instruction: reads 4 consecutive bytes (opcode, p0, p1, p2) over a req/ack port, then presents them to the decoder/execute stage over a valid/ready handshake.
- Handles JUMP, STOP and execute-stage redirects, so the decoder never drives the fetch address itself.

Parameters:
- DATA_WIDTH, 8, width of opcode/operand bytes and mem_rdata.
- ADDR_WIDTH, 8, width of PC and mem_addr.
- RESET_PC, 0, PC value after reset and after restart.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- cache_init_load_finished  in  1  level; instruction cache holds valid program.
- mem_req  out  1  fetch request to instruction cache.
- mem_addr  out  ADDR_WIDTH  fetch address; stable while mem_req=1 and mem_ack=0.
- mem_ack  in  1  cache accepted request; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  fetched byte.
- ir_valid  out  1  instruction bundle valid.
- ir_ready  in  1  decoder accepts bundle.
- ir_op  out  DATA_WIDTH  opcode byte.
- ir_p0  out  DATA_WIDTH  first operand.
- ir_p1  out  DATA_WIDTH  second operand.
- ir_p2  out  DATA_WIDTH  third operand.
- redirect  in  1  one-cycle pulse: execute stage requests a branch.
- redirect_addr  in  ADDR_WIDTH  branch target, sampled with redirect.
- restart  in  1  one-cycle pulse: leave HALT and restart at RESET_PC.
- pc  out  ADDR_WIDTH  address of the opcode of the bundle currently held or being fetched.
- halted  out  1  sequencer is in HALT.

Behaviour:
- Reset values: state=WAIT_INIT; PC=RESET_PC; mem_req=0; mem_addr=RESET_PC; ir_valid=0; ir_op/p0/p1/p2=0; halted=0; pending redirect cleared.
- States: WAIT_INIT, FETCH_OP, FETCH_P0, FETCH_P1, FETCH_P2, ISSUE, HALT.
- WAIT_INIT:
  - -> FETCH_OP on the first cycle cache_init_load_finished=1.
  - redirect and restart are ignored here.
- FETCH_x states:
  - mem_req=1 and mem_addr=fetch pointer.
  - On mem_ack: capture mem_rdata into the matching byte register, increment the fetch pointer, advance to the next state.
  - mem_req stays high across states, so back-to-back acks give one byte per cycle.
  - Best case is 4 cycles from entering FETCH_OP to ir_valid=1.
- Address arithmetic: the fetch pointer increments modulo 2^ADDR_WIDTH; a bundle starting at 8'hFE fetches FE, FF, 00, 01.
- ISSUE:
  - mem_req=0; ir_valid=1; bundle held stable until ir_valid && ir_ready.
  - On handshake, if ir_op=8'h0E (STOP): -> HALT.
  - On handshake, if ir_op=8'h02 (JUMP): PC <= ir_p0[ADDR_WIDTH-1:0], -> FETCH_OP.
  - On handshake, otherwise: PC <= fetch pointer (PC+4), -> FETCH_OP.
  - ir_valid drops the cycle after the handshake.
- Redirect:
  - A redirect pulse in any state except WAIT_INIT/HALT sets a pending flag and latches redirect_addr.
  - A later redirect before it is consumed overwrites the latched address.
  - When entering FETCH_OP, a pending redirect overrides the next PC (including a JUMP target) and clears the flag.
  - Redirect arriving in FETCH_P0..P2, or in ISSUE before the handshake: the in-flight bundle is squashed, i.e. the current byte request completes (mem_req not dropped mid-request), then -> FETCH_OP at the target without asserting ir_valid.
  - Redirect in the same cycle as the ISSUE handshake: the bundle is issued, and the redirect applies to the next fetch.
- HALT:
  - halted=1, mem_req=0, ir_valid=0.
  - restart -> FETCH_OP with PC=RESET_PC and the pending redirect cleared.
  - Redirect is ignored.
- cache_init_load_finished falling after WAIT_INIT has no effect.
- Reset mid-transaction: all state returns to reset values next cycle; an outstanding request is abandoned (mem_req=0).

Optional Feature:
- Macro IR_ILLEGAL_OP_CHECK_EN.
- Defined:
  - At ISSUE entry, ir_op is checked against the legal set {00,02,0E,0F,10,11,12,20,21,22,23,28,29,2A,80,81} (hex).
  - An illegal opcode is not issued (ir_valid stays 0); the state goes to HALT and extra output illegal_op (1 bit, reset 0) is set to 1.
  - illegal_op is cleared by restart or rst_n; pc holds the faulting address.
- Undefined: the illegal_op port does not exist, and every opcode is issued.

Test Plan:
- Reset, cache_init_load_finished=0 for 10 cycles, then 1 -> mem_req rises the next cycle with mem_addr=00.
- Memory 00..07 = 20,01,02,03,21,04,05,06; ack every cycle; ir_ready=1 -> bundle {20,01,02,03} with pc=00, then bundle {21,04,05,06} with pc=04.
- Bundle {02,40,00,00} at 08 -> after handshake, next mem_addr=40.
- ir_ready held 0 for 5 cycles -> ir_valid and bundle stable, no mem_req.
- redirect with addr 0x80 during FETCH_P1 -> no ir_valid for that bundle; next opcode fetched from 80.
- STOP {0E,..} -> halted=1 and mem_req=0; restart pulse -> fetch at RESET_PC. Wrap case: start at FE -> addresses FE, FF, 00, 01.
